systolic_data_setup: RTL and testbench

//  Producer for the systolic input of the matrix multiply unit. Takes one unskewed
//  row vector per accepted cycle and emits it diagonally skewed: lane i delayed i

---
 rtl/tpu_pkg.sv | 6 +
 rtl/byte_delay_line.sv | 40 ++++
 rtl/systolic_data_setup.sv | 69 ++++++
 tb/tb_systolic_data_setup.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared byte type and the data-setup FSM state encoding.
package tpu_pkg;
  localparam int BYTE_WIDTH = 8;
  typedef logic [BYTE_WIDTH-1:0] byte_type;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} setup_state_type;
endpackage

// File: rtl/byte_delay_line.sv
// byte_delay_line: enable-gated DEPTH-stage shift register for a byte plus its valid bit.
module byte_delay_line
  import tpu_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     enable,
  input  byte_type data_in,
  input  logic     valid_in,
  output byte_type data_out,
  output logic     valid_out
);
  generate
    if (DEPTH == 0) begin : g_pass
      logic unused;
      assign unused = &{1'b0, clk, rst, enable};
      assign data_out = data_in;
      assign valid_out = valid_in;
    end else begin : g_shift
      byte_type data_q [DEPTH];
      logic [DEPTH-1:0] valid_q;
      always_ff @(posedge clk)
        if (rst) begin
          data_q <= '{default: '0};
          valid_q <= '0;
        end else if (enable) begin
          data_q[0] <= data_in;
          valid_q[0] <= valid_in;
          for (int k = 1; k < DEPTH; k++) begin
            data_q[k] <= data_q[k-1];
            valid_q[k] <= valid_q[k-1];
          end
        end
      assign data_out = data_q[DEPTH-1];
      assign valid_out = valid_q[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/systolic_data_setup.sv
// systolic_data_setup: skews unskewed rows diagonally into the systolic array and tracks batch completion.
module systolic_data_setup
  import tpu_pkg::*;
#(
  parameter int MATRIX_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  byte_type                data_in [MATRIX_WIDTH],
  input  logic                    data_valid,
  input  logic                    data_signed,
  input  logic                    last_in,
  output byte_type                systolic_data [MATRIX_WIDTH],
  output logic                    systolic_signed,
  output logic [MATRIX_WIDTH-1:0] lane_valid,
  output logic                    busy,
  output logic                    done
);
  localparam int CW = $clog2(MATRIX_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(MATRIX_WIDTH - 1);
  logic accept;
  byte_type dl_data [MATRIX_WIDTH];
  logic [MATRIX_WIDTH-1:0] dl_valid;
  setup_state_type state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  assign accept = data_valid & enable;
  generate
    for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_lane
      byte_delay_line #(.DEPTH(i)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .data_in  (accept ? data_in[i] : '0),
        .valid_in (accept),
        .data_out (dl_data[i]),
        .valid_out(dl_valid[i])
      );
    end
  endgenerate
  // Lane outputs are zeroed whenever their valid is low so bubbles never leak stale bytes.
  always_ff @(posedge clk)
    if (rst) begin
      systolic_data <= '{default: '0};
      systolic_signed <= 1'b0;
      lane_valid <= '0;
    end else if (enable) begin
      for (int k = 0; k < MATRIX_WIDTH; k++) systolic_data[k] <= dl_valid[k] ? dl_data[k] : '0;
      systolic_signed <= data_signed & accept;
      lane_valid <= dl_valid;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= next_state;
      cnt <= next_cnt;
    end
  // cnt counts the remaining cycles until the last row's final lane reaches the output.
  always_comb begin
    next_state = accept ? (last_in ? DRAIN : STREAM)
               : (enable && state == DRAIN && cnt == '0) ? IDLE : state;
    next_cnt = (accept && last_in) ? CNT_MAX
             : (enable && state == DRAIN && cnt != '0) ? cnt - 1'b1 : cnt;
    done = state == DRAIN && cnt == '0 && enable && !accept;
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_systolic_data_setup.sv
// tb_systolic_data_setup: random and directed rows into 4- and 14-lane instances, checked against a tick-history model.
module tb_systolic_data_setup;
  import tpu_pkg::*;
  localparam int WA = 4;
  localparam int WB = 14;
  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, data_valid = 1'b0, data_signed = 1'b0, last_in = 1'b0;
  byte_type din [WB];
  byte_type din_a [WA];
  byte_type sd_a [WA];
  byte_type sd_b [WB];
  logic [WA-1:0] lv_a;
  logic [WB-1:0] lv_b;
  logic ss_a, ss_b, busy_a, busy_b, done_a, done_b;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct packed {
    logic v;
    logic s;
    logic l;
    logic [WB-1:0][7:0] d;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < WA; i++) din_a[i] = din[i];

  systolic_data_setup #(.MATRIX_WIDTH(WA)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .data_in(din_a), .data_valid(data_valid),
    .data_signed(data_signed), .last_in(last_in), .systolic_data(sd_a),
    .systolic_signed(ss_a), .lane_valid(lv_a), .busy(busy_a), .done(done_a));
  systolic_data_setup #(.MATRIX_WIDTH(WB)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .data_in(din), .data_valid(data_valid),
    .data_signed(data_signed), .last_in(last_in), .systolic_data(sd_b),
    .systolic_signed(ss_b), .lane_valid(lv_b), .busy(busy_b), .done(done_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  // Lane i currently shows whatever was injected i enabled ticks before the newest one.
  function automatic logic exp_vld(int i);
    int n = q.size();
    return n > i && q[n-1-i].v;
  endfunction
  function automatic logic [7:0] exp_lane(int i);
    int n = q.size();
    return exp_vld(i) ? q[n-1-i].d[i] : 8'h00;
  endfunction
  function automatic logic exp_done(int w);
    int n = q.size();
    if (!enable || data_valid || n < w) return 1'b0;
    if (!(q[n-w].v && q[n-w].l)) return 1'b0;
    for (int k = 0; k < w - 1; k++) if (q[n-1-k].v) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic exp_busy(int w);
    for (int j = q.size() - 1; j >= 0; j--)
      if (q[j].v) return !(q[j].l && (q.size() - 1 - j) >= w);
    return 1'b0;
  endfunction

  task automatic compare_all();
    logic [WB-1:0] ev;
    for (int i = 0; i < WB; i++) ev[i] = exp_vld(i);
    for (int i = 0; i < WA; i++) chk($sformatf("lane_a%0d", i), sd_a[i], exp_lane(i));
    for (int i = 0; i < WB; i++) chk($sformatf("lane_b%0d", i), sd_b[i], exp_lane(i));
    chk("vld_a", lv_a, ev[WA-1:0]);
    chk("vld_b", lv_b, ev);
    chk("sgn_a", ss_a, q.size() > 0 && q[q.size()-1].v && q[q.size()-1].s);
    chk("sgn_b", ss_b, q.size() > 0 && q[q.size()-1].v && q[q.size()-1].s);
    chk("busy_a", busy_a, exp_busy(WA));
    chk("busy_b", busy_b, exp_busy(WB));
    chk("done_a", done_a, exp_done(WA));
    chk("done_b", done_b, exp_done(WB));
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic s, input logic l, input bit cmp);
    ent_t x;
    rst = r;
    enable = e;
    data_valid = v;
    data_signed = s;
    last_in = l;
    @(negedge clk);
    if (cmp) compare_all();
    @(posedge clk);
    if (r) q.delete();
    else if (e) begin
      x.v = v;
      x.s = s;
      x.l = l;
      for (int i = 0; i < WB; i++) x.d[i] = din[i];
      q.push_back(x);
    end
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic randomize_row();
    for (int i = 0; i < WB; i++) din[i] = 8'($urandom);
  endtask

  initial begin
    randomize_row();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_vld", lv_a, 4'b0000);
    chk("rst_busy", busy_a, 1'b0);
    for (int i = 0; i < WB; i++) din[i] = 8'(i + 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk("t1_lane3", sd_a[3], 8'd4);
    chk("t1_vld3", lv_a, 4'b1000);
    idle(16);
    for (int k = 0; k < 4; k++) begin
      randomize_row();
      step(1'b0, 1'b1, 1'b1, 1'b0, k == 3, 1'b1);
    end
    idle(16);
    randomize_row();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    randomize_row();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(16);
    randomize_row();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1);
    randomize_row();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(16);
    randomize_row();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_busy", busy_a, 1'b0);
    idle(16);
    randomize_row();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(3);
    randomize_row();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(16);
    randomize_row();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(13);
    randomize_row();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(20);
    for (int k = 0; k < 800; k++) begin
      randomize_row();
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, 1'($urandom),
           1'($urandom), $urandom_range(0, 4) == 0, 1'b1);
    end
    idle(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
